// File: rtl/pipe_pkg.sv
// Shared widths and control-bundle layouts for the inter-stage pipeline registers.
// The stage wrappers use these to pack and unpack bundles around pipe_stage_elastic.
package pipe_pkg;

  localparam int DE_CTRL_W = 16;
  localparam int DE_DATA_W = 105;
  localparam int EM_CTRL_W = 4;
  localparam int EM_DATA_W = 68;
  localparam int MW_CTRL_W = 3;
  localparam int MW_DATA_W = 68;

  // D/E control bundle; a bubble is all-zero, so regwrite and memwrite are clear.
  typedef struct packed {
    logic       pcsrc;
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       branch;
    logic       alusrc;
    logic [2:0] alucontrol;
    logic [1:0] flagwrite;
    logic       cond;
    logic [3:0] flags;
  } de_ctrl_t;

endpackage

// File: rtl/pipe_slot.sv
// One valid+ctrl+data holding register. Any slot without a valid beat
// holds all-zero ctrl and data, so an empty slot always reads as a bubble.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DE_CTRL_W,
  parameter int DATA_W = DE_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              load,
  input  logic              unload,
  input  logic [CTRL_W-1:0] nxt_ctrl,
  input  logic [DATA_W-1:0] nxt_data,
  output logic              vld,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              vld_p1;
  logic [CTRL_W-1:0] ctrl_p1;
  logic [DATA_W-1:0] data_p1;

  // Slot register boundary: reset/flush, then load, then drain to a bubble.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
      data_p1 <= '0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      ctrl_p1 <= nxt_ctrl;
      data_p1 <= nxt_data;
    end else if (unload) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
      data_p1 <= '0;
    end
  end

  assign vld  = vld_p1;
  assign ctrl = ctrl_p1;
  assign data = data_p1;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Parametrised elastic pipeline register with valid/ready, stall and flush-to-bubble.
// SKID=1 adds a second slot so in_ready comes straight from a register.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DE_CTRL_W,
  parameter int DATA_W = DE_DATA_W,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  logic              main_v;
  logic              skid_v;
  logic              accept;
  logic              emit;
  logic              main_load;
  logic [CTRL_W-1:0] main_nxt_ctrl;
  logic [DATA_W-1:0] main_nxt_data;

  assign accept = in_valid & in_ready;
  assign emit   = main_v & out_ready;

  generate
    if (SKID) begin : g_skid
      logic              skid_load;
      logic [CTRL_W-1:0] skid_ctrl;
      logic [DATA_W-1:0] skid_data;

      // skid_v is a register, so in_ready only sees reset combinationally.
      assign in_ready      = ~skid_v & ~reset;
      assign main_load     = (skid_v & emit) | (accept & (~main_v | emit));
      assign skid_load     = accept & main_v & ~emit;
      assign main_nxt_ctrl = skid_v ? skid_ctrl : in_ctrl;
      assign main_nxt_data = skid_v ? skid_data : in_data;

      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk      (clk),
        .reset    (reset),
        .clr      (flush),
        .load     (skid_load),
        .unload   (emit),
        .nxt_ctrl (in_ctrl),
        .nxt_data (in_data),
        .vld      (skid_v),
        .ctrl     (skid_ctrl),
        .data     (skid_data)
      );
    end else begin : g_single
      assign in_ready      = ~reset & (~main_v | out_ready);
      assign main_load     = accept;
      assign main_nxt_ctrl = in_ctrl;
      assign main_nxt_data = in_data;
      assign skid_v        = 1'b0;
    end
  endgenerate

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk      (clk),
    .reset    (reset),
    .clr      (flush),
    .load     (main_load),
    .unload   (emit),
    .nxt_ctrl (main_nxt_ctrl),
    .nxt_data (main_nxt_data),
    .vld      (main_v),
    .ctrl     (out_ctrl),
    .data     (out_data)
  );

  assign out_valid = main_v;

endmodule
